// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status-range constants, message-length decode and
// the state types used by the SPI transmitter and its byte shifter.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] POLY_AT  = 8'hA0;
  localparam logic [7:0] CC       = 8'hB0;
  localparam logic [7:0] PROG     = 8'hC0;
  localparam logic [7:0] CHAN_AT  = 8'hD0;
  localparam logic [7:0] PITCH    = 8'hE0;
  localparam logic [7:0] SYS      = 8'hF0;

  // Transmitter sequencing: idle, a byte in flight in the shifter, or the
  // idle-low gap that follows every byte.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  // Shifter phase: LOW holds sclk low with the current bit on mosi, HIGH
  // holds sclk high so the receiver samples on the rising edge.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_LOW  = 2'd1,
    PH_HIGH = 2'd2
  } shift_phase_t;

  // Number of bytes in a channel message, status byte included.
  // Returns 0 for a byte without bit7 set (not a status byte).
  // System messages go out as the status byte alone (no SysEx payload).
  function automatic logic [1:0] msg_len(input logic [7:0] status);
    logic [1:0] len;
    if (!status[7]) begin
      len = 2'd0;
    end else if (status >= SYS) begin
      len = 2'd1;
    end else if ((status >= PROG) && (status < PITCH)) begin
      len = 2'd2;
    end else begin
      len = 2'd3;
    end
    return len;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: on load it sends one byte MSB first, each bit as a
// LOW phase then a HIGH phase of CLK_DIV clocks. o_done marks the final clock
// of the last HIGH phase so the sequencer can enter its gap on the next cycle.
module spi_byte_shifter
  import midi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_done
);

  localparam int                 DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  shift_phase_t     r_phase;
  shift_phase_t     w_phaseNext;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_divNext;
  logic [2:0]       r_bit;
  logic [2:0]       w_bitNext;
  logic [7:0]       r_shift;
  logic [7:0]       w_shiftNext;
  logic             r_sclk;
  logic             w_sclkNext;

  // Mosi is the shift register MSB: it only moves when a HIGH phase ends,
  // and after the eighth shift the register is all zeros, so mosi idles low.
  assign o_mosi = r_shift[7];
  assign o_sclk = r_sclk;

  // Next-phase and datapath decode for the LOW/HIGH divider.
  always_comb begin
    w_phaseNext = r_phase;
    w_divNext   = r_div;
    w_bitNext   = r_bit;
    w_shiftNext = r_shift;
    w_sclkNext  = r_sclk;
    o_done      = 1'b0;
    case (r_phase)
      PH_IDLE: begin
        if (i_load) begin
          w_phaseNext = PH_LOW;
          w_divNext   = '0;
          w_bitNext   = 3'd0;
          w_shiftNext = i_byte;
          w_sclkNext  = 1'b0;
        end
      end
      PH_LOW: begin
        if (r_div == DIV_LAST) begin
          w_phaseNext = PH_HIGH;
          w_divNext   = '0;
          w_sclkNext  = 1'b1;
        end else begin
          w_divNext = r_div + 1'b1;
        end
      end
      PH_HIGH: begin
        if (r_div == DIV_LAST) begin
          w_divNext   = '0;
          w_sclkNext  = 1'b0;
          w_shiftNext = {r_shift[6:0], 1'b0};
          if (r_bit == 3'd7) begin
            w_phaseNext = PH_IDLE;
            w_bitNext   = 3'd0;
            o_done      = 1'b1;
          end else begin
            w_phaseNext = PH_LOW;
            w_bitNext   = r_bit + 3'd1;
          end
        end else begin
          w_divNext = r_div + 1'b1;
        end
      end
      default: begin
        w_phaseNext = PH_IDLE;
        w_sclkNext  = 1'b0;
        w_shiftNext = '0;
      end
    endcase
  end

  // Phase, divider, bit index, shift register and sclk registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase <= PH_IDLE;
      r_div   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_sclk  <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      r_div   <= w_divNext;
      r_bit   <= w_bitNext;
      r_shift <= w_shiftNext;
      r_sclk  <= w_sclkNext;
    end
  end

endmodule

// File: rtl/midi_spi_tx.sv
// MIDI channel-message SPI transmitter: accepts one 1-3 byte message over a
// valid/ready handshake and sends status then data bytes, each followed by an
// idle-low gap. Invalid status bytes are consumed and flagged, never sent.
module midi_spi_tx
  import midi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_msg_valid,
  output logic       o_msg_ready,
  input  logic [7:0] i_msg_status,
  input  logic [7:0] i_msg_data1,
  input  logic [7:0] i_msg_data2,
  output logic       o_SPI_sclk,
  output logic       o_SPI_mosi,
  output logic       o_busy,
  output logic [1:0] o_byte_counter,
  output logic       o_err_status
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  tx_state_t        r_state;
  tx_state_t        w_stateNext;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] w_gapNext;
  logic [1:0]       r_byteCnt;
  logic [1:0]       w_byteCntNext;
  logic [1:0]       r_len;
  logic [7:0]       r_data1;
  logic [7:0]       r_data2;
  logic             r_err;
  logic             w_errNext;
  logic             w_accept;
  logic [1:0]       w_statusLen;
  logic             w_load;
  logic [7:0]       w_loadByte;
  logic             w_shDone;

  assign w_accept       = (r_state == TX_IDLE) && i_msg_valid;
  assign w_statusLen    = msg_len(i_msg_status);
  assign o_msg_ready    = (r_state == TX_IDLE);
  assign o_busy         = (r_state != TX_IDLE);
  assign o_byte_counter = r_byteCnt;
  assign o_err_status   = r_err;

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .i_byte    (w_loadByte),
    .o_sclk    (o_SPI_sclk),
    .o_mosi    (o_SPI_mosi),
    .o_done    (w_shDone)
  );

  // Sequencer next-state: start a message, wait for the shifter, then run the
  // gap and either load the next held byte or return to idle.
  always_comb begin
    w_stateNext   = r_state;
    w_gapNext     = r_gap;
    w_byteCntNext = r_byteCnt;
    w_errNext     = 1'b0;
    w_load        = 1'b0;
    w_loadByte    = i_msg_status;
    case (r_state)
      TX_IDLE: begin
        if (w_accept) begin
          if (w_statusLen == 2'd0) begin
            w_errNext = 1'b1;
          end else begin
            w_stateNext   = TX_SHIFT;
            w_load        = 1'b1;
            w_loadByte    = i_msg_status;
            w_byteCntNext = 2'd0;
            w_gapNext     = '0;
          end
        end
      end
      TX_SHIFT: begin
        if (w_shDone) begin
          w_stateNext = TX_GAP;
          w_gapNext   = '0;
        end
      end
      TX_GAP: begin
        if (r_gap == GAP_LAST) begin
          if ((r_byteCnt + 2'd1) < r_len) begin
            w_stateNext   = TX_SHIFT;
            w_load        = 1'b1;
            w_loadByte    = (r_byteCnt == 2'd0) ? r_data1 : r_data2;
            w_byteCntNext = r_byteCnt + 2'd1;
          end else begin
            w_stateNext   = TX_IDLE;
            w_byteCntNext = 2'd0;
          end
        end else begin
          w_gapNext = r_gap + 1'b1;
        end
      end
      default: begin
        w_stateNext   = TX_IDLE;
        w_byteCntNext = 2'd0;
      end
    endcase
  end

  // Sequencer state, gap counter, byte index and error pulse registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= TX_IDLE;
      r_gap     <= '0;
      r_byteCnt <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_gap     <= w_gapNext;
      r_byteCnt <= w_byteCntNext;
      r_err     <= w_errNext;
    end
  end

  // Holding registers: capture the data bytes and length of a valid message
  // at accept so later input changes cannot disturb the transfer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_len   <= 2'd0;
      r_data1 <= 8'h00;
      r_data2 <= 8'h00;
    end else if (w_accept && (w_statusLen != 2'd0)) begin
      r_len   <= w_statusLen;
      r_data1 <= i_msg_data1;
      r_data2 <= i_msg_data2;
    end
  end

endmodule

// File: tb/tb_midi_spi_tx.sv
// Directed bench for midi_spi_tx with a mode-0 sampler feeding a byte
// scoreboard, plus handshake/timing checks around every message.
module tb_midi_spi_tx;

  localparam int CD       = 2;
  localparam int GAP      = 4;
  localparam int BYTE_CYC = 16 * CD + GAP;
  localparam int LIMIT    = 400;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_msg_valid = 1'b0;
  logic [7:0] i_msg_status = 8'h00;
  logic [7:0] i_msg_data1 = 8'h00;
  logic [7:0] i_msg_data2 = 8'h00;
  logic       o_msg_ready;
  logic       o_SPI_sclk;
  logic       o_SPI_mosi;
  logic       o_busy;
  logic [1:0] o_byte_counter;
  logic       o_err_status;

  int   checks = 0;
  int   errors = 0;
  int   rises = 0;
  int   bitCnt = 0;
  logic prevSclk = 1'b0;
  logic [7:0] rxShift = 8'h00;
  exp_t expQ[$];
  exp_t sbEntry;

  midi_spi_tx #(
    .CLK_DIV    (CD),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_msg_valid    (i_msg_valid),
    .o_msg_ready    (o_msg_ready),
    .i_msg_status   (i_msg_status),
    .i_msg_data1    (i_msg_data1),
    .i_msg_data2    (i_msg_data2),
    .o_SPI_sclk     (o_SPI_sclk),
    .o_SPI_mosi     (o_SPI_mosi),
    .o_busy         (o_busy),
    .o_byte_counter (o_byte_counter),
    .o_err_status   (o_err_status)
  );

  always #5 clk = ~clk;

  function automatic int tbLen(input logic [7:0] s);
    if (s < 8'h80) return 0;
    if (s >= 8'hF0) return 1;
    if ((s >= 8'hC0) && (s <= 8'hDF)) return 2;
    return 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the message inputs and push the bytes that must appear on the wire.
  task automatic applyStimulus(input logic valid, input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    exp_t e;
    int   len;
    i_msg_valid  = valid;
    i_msg_status = s;
    i_msg_data1  = d1;
    i_msg_data2  = d2;
    if (valid) begin
      len = tbLen(s);
      if (len >= 1) begin e.data = s;  e.idx = 2'd0; expQ.push_back(e); end
      if (len >= 2) begin e.data = d1; e.idx = 2'd1; expQ.push_back(e); end
      if (len == 3) begin e.data = d2; e.idx = 2'd2; expQ.push_back(e); end
    end
  endtask

  // Called at a negedge with a valid message already driven. Lets it be
  // accepted, applies the follow-up inputs, then times the transfer.
  task automatic sendMessage(input string tag, input int expLen, input logic nValid,
                             input logic [7:0] ns, input logic [7:0] nd1, input logic [7:0] nd2);
    int         k;
    int         firstRise;
    int         risesBefore;
    logic [7:0] s;
    s = i_msg_status;
    checkOutput({tag, "_ready_pre"}, o_msg_ready, 1);
    risesBefore = rises;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_busy_n1"}, o_busy, 1);
    checkOutput({tag, "_ready_n1"}, o_msg_ready, 0);
    checkOutput({tag, "_mosi_n1"}, o_SPI_mosi, s[7]);
    checkOutput({tag, "_sclk_n1"}, o_SPI_sclk, 0);
    checkOutput({tag, "_cnt_n1"}, o_byte_counter, 0);
    applyStimulus(nValid, ns, nd1, nd2);
    k = 0;
    firstRise = -1;
    while (!o_msg_ready && (k < LIMIT)) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (o_SPI_sclk && (firstRise < 0)) firstRise = k;
    end
    checkOutput({tag, "_cycles"}, k, expLen * BYTE_CYC);
    checkOutput({tag, "_first_rise"}, firstRise, CD);
    checkOutput({tag, "_rises"}, rises - risesBefore, 8 * expLen);
    checkOutput({tag, "_busy_end"}, o_busy, 0);
    checkOutput({tag, "_cnt_end"}, o_byte_counter, 0);
    checkOutput({tag, "_mosi_end"}, o_SPI_mosi, 0);
  endtask

  // Mode-0 sampler: on each sclk rise shift in mosi; every 8 bits compare the
  // byte and its byte_counter index against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n) begin
      bitCnt  = 0;
      rxShift = 8'h00;
    end else if (o_SPI_sclk && !prevSclk) begin
      rises++;
      rxShift = {rxShift[6:0], o_SPI_mosi};
      bitCnt++;
      if (bitCnt == 8) begin
        bitCnt = 0;
        checks++;
        assert (expQ.size() > 0) else begin
          errors++;
          $error("[TB] FAIL sb_extra_byte observed=0x%0h expected=none", rxShift);
        end
        if (expQ.size() > 0) begin
          sbEntry = expQ.pop_front();
          checkOutput("sb_byte", rxShift, sbEntry.data);
          checkOutput("sb_byte_counter", o_byte_counter, sbEntry.idx);
        end
      end
    end
    prevSclk = o_SPI_sclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r0;
    int guard;
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", o_msg_ready, 1);
    checkOutput("rst_sclk", o_SPI_sclk, 0);
    checkOutput("rst_mosi", o_SPI_mosi, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_cnt", o_byte_counter, 0);
    checkOutput("rst_err", o_err_status, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_rst_ready", o_msg_ready, 1);

    $display("[TB] note on");
    applyStimulus(1'b1, 8'h90, 8'h3C, 8'h64);
    sendMessage("noteon", 3, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("[TB] program change");
    @(negedge clk);
    applyStimulus(1'b1, 8'hC5, 8'h10, 8'hAA);
    sendMessage("prog", 2, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("[TB] timing clock");
    @(negedge clk);
    applyStimulus(1'b1, 8'hF8, 8'h55, 8'h66);
    sendMessage("clock", 1, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("[TB] invalid status");
    @(negedge clk);
    r0 = rises;
    applyStimulus(1'b1, 8'h3C, 8'h11, 8'h22);
    @(posedge clk);
    @(negedge clk);
    checkOutput("err_pulse", o_err_status, 1);
    checkOutput("err_ready", o_msg_ready, 1);
    checkOutput("err_busy", o_busy, 0);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    checkOutput("err_pulse_end", o_err_status, 0);
    repeat (10) @(negedge clk);
    checkOutput("err_no_sclk", rises - r0, 0);
    checkOutput("err_ready_stays", o_msg_ready, 1);

    $display("[TB] held valid, two messages");
    applyStimulus(1'b1, 8'hD3, 8'h55, 8'h01);
    sendMessage("heldA", 2, 1'b1, 8'hA1, 8'h80, 8'hFF);
    sendMessage("heldB", 3, 1'b0, 8'h00, 8'h00, 8'h00);

    $display("[TB] reset mid-transfer");
    @(negedge clk);
    applyStimulus(1'b1, 8'h90, 8'h3C, 8'h64);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
    guard = 0;
    while (!((o_byte_counter == 2'd1) && (bitCnt == 3)) && (guard < LIMIT)) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("abort_reached", (guard < LIMIT), 1);
    repeat (2) @(negedge clk);
    checkOutput("abort_mosi_bit4", o_SPI_mosi, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sclk", o_SPI_sclk, 0);
    checkOutput("abort_mosi", o_SPI_mosi, 0);
    checkOutput("abort_ready", o_msg_ready, 1);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_cnt", o_byte_counter, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'hB0, 8'h07, 8'h7F);
    sendMessage("cc_after_rst", 3, 1'b0, 8'h00, 8'h00, 8'h00);

    repeat (5) @(negedge clk);
    checkOutput("sb_drained", expQ.size(), 0);
    checkOutput("final_idle_sclk", o_SPI_sclk, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
